mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the EX stage of the pipelined MIPS CPU.
- Sits beside the combinational ALU and owns the HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU with configurable latency, and MTHI/MTLO writes.
- Exposes busy/done so hazard logic can stall MFHI/MFLO and new MDU ops.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (even, >=8).
- MULT_CYCLES, 5, cycles from accepted MULT/MULTU to HI/LO update (>=1).
- DIV_CYCLES, 10, cycles from accepted DIV/DIVU to HI/LO update (>=1).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  strobe: op/A/B valid this cycle.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- A  input  WIDTH  rs operand (dividend/multiplicand; MTHI/MTLO data).
- B  input  WIDTH  rt operand (divisor/multiplier).
- rd_sel  input  1  read select: 1 = HI, 0 = LO.
- rd_data  output  WIDTH  combinational: rd_sel ? hi : lo.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  registered; high while an operation is in flight.
- done  output  1  registered; one-cycle pulse the cycle after HI/LO are written by MULT/DIV.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (any time, including mid-operation): hi=0, lo=0, busy=0, done=0, cycle counter=0, latched operands discarded. No result is written after reset release.
- Accept: at an edge where start=1, busy=0 and op is 000-011:
  - latch A, B and op;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - busy=1 from that edge.
- Countdown: each later edge decrements the counter. At the edge where the counter goes 1->0:
  - HI/LO written;
  - busy=0;
  - done=1 for exactly one cycle.
- Net: busy is high for exactly LAT cycles. HI/LO are visible LAT edges after the accept edge.
- start while busy=1: ignored entirely. Operands are not relatched and the counter is not reset. Upstream must stall.
- MTHI/MTLO with start=1 and busy=0: hi (or lo) <= A at that edge; busy/done unaffected. Ignored while busy.
- op 110/111: no effect.
- MULT: signed 2*WIDTH product of the latched operands; hi = upper WIDTH bits, lo = lower WIDTH bits.
- MULTU: same as MULT, unsigned.
- DIV (signed):
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Overflow case A = most-negative, B = -1: lo = most-negative, hi = 0.
- DIVU: unsigned quotient -> lo, remainder -> hi.
- Divide by zero (DIV or DIVU, B=0): full DIV_CYCLES latency and done pulse still occur; hi and lo keep their prior values.
- Operand capture: result computed only from operands latched at accept. A/B changes during busy have no effect.
- Internal implementation (iterative or single-shot with delay counter) is free, provided latency and results match exactly.
- The write to HI/LO at completion cannot coincide with an MTHI/MTLO write, because MTHI/MTLO are ignored while busy.
- rd_data/hi/lo during busy show the old values. Hazard logic must stall MFHI/MFLO on busy=1 or start=1 with op 000-011.

Test Plan:
- Reset then MULT A=0xFFFFFFFD (-3), B=5 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulses once.
- MULTU A=0xFFFFFFFF, B=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE. Then DIVU A=7, B=0 -> busy 10 cycles, done pulses, hi/lo unchanged.
- DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU A=100, B=7 accepted; second start MULT A=2, B=3 issued on cycle 3 of busy -> ignored; final lo=14, hi=2, busy low at cycle 10.
- MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 on consecutive edges, busy=0 -> hi/lo updated on those edges. rd_sel=1 gives 0x12345678, rd_sel=0 gives 0x9ABCDEF0.
- MULT accepted, reset asserted asynchronously mid-cycle on cycle 2 -> hi=lo=0, busy=0 immediately. No done pulse or HI/LO write after release.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Purpose : handshake and result bundle between the EX stage and the multiply/divide unit.
// Ports   : start/op/A/B/rd_sel flow into the unit (slave); rd_data/hi/lo/busy/done flow out.
// Backpr. : none carried here; the issuing side stalls on busy.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;    // op/A/B valid this cycle
  logic [2:0]       op;       // 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
  logic [WIDTH-1:0] A;        // rs: dividend / multiplicand / MTHI-MTLO data
  logic [WIDTH-1:0] B;        // rt: divisor / multiplier
  logic             rd_sel;   // 1 = HI, 0 = LO
  logic [WIDTH-1:0] rd_data;  // rd_sel ? hi : lo
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  // Issuing side (EX stage / testbench)
  modport master (
    output start, op, A, B, rd_sel,
    input  rd_data, hi, lo, busy, done
  );

  // The unit itself
  modport slave (
    input  start, op, A, B, rd_sel,
    output rd_data, hi, lo, busy, done
  );
endinterface

// File: rtl/mult_div_unit.sv
// Purpose : multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers, plus MTHI/MTLO writes.
// Latency : HI/LO written MULT_CYCLES / DIV_CYCLES edges after the accept edge; MTHI/MTLO take effect on their edge.
// Backpr. : busy is high while an op is in flight; any start seen while busy is dropped, so upstream must stall.
// Ports   : clk, reset (async, active-high); bus (slave modport): start, op, A, B, rd_sel in;
//           rd_data, hi, lo, busy, done out.
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  mult_div_unit_if.slave       bus
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           r_state,       w_state_nxt;
  logic [CW-1:0]    r_cnt,         w_cnt_nxt;
  logic [WIDTH-1:0] r_a,           w_a_nxt;
  logic [WIDTH-1:0] r_b,           w_b_nxt;
  logic             r_is_div,      w_is_div_nxt;
  logic             r_is_unsigned, w_is_unsigned_nxt;
  logic [WIDTH-1:0] r_hi,          w_hi_nxt;
  logic [WIDTH-1:0] r_lo,          w_lo_nxt;
  logic             r_busy,        w_busy_nxt;
  logic             r_done,        w_done_nxt;

  // ---------------------------------------------------------------------------
  // Datapath: single-shot compute from the latched operands. The counter only
  // paces when the result is committed; nothing here looks at live A/B.
  // ---------------------------------------------------------------------------
  logic                   w_sign_a;
  logic                   w_sign_b;
  logic [2*WIDTH-1:0]     w_a_ext;
  logic [2*WIDTH-1:0]     w_b_ext;
  logic [2*WIDTH-1:0]     w_prod;
  logic [WIDTH-1:0]       w_mag_a;
  logic [WIDTH-1:0]       w_mag_b;
  logic [WIDTH-1:0]       w_div_b;
  logic [WIDTH-1:0]       w_q_mag;
  logic [WIDTH-1:0]       w_r_mag;
  logic [WIDTH-1:0]       w_quot;
  logic [WIDTH-1:0]       w_rem;
  logic                   w_b_zero;
  logic                   w_accept_md;
  logic                   w_last;

  assign w_sign_a = ~r_is_unsigned & r_a[WIDTH-1];
  assign w_sign_b = ~r_is_unsigned & r_b[WIDTH-1];

  // Sign- (or zero-) extending to 2*WIDTH lets one unsigned multiplier serve
  // both MULT and MULTU: the low 2*WIDTH bits of the product are identical.
  assign w_a_ext = {{WIDTH{w_sign_a}}, r_a};
  assign w_b_ext = {{WIDTH{w_sign_b}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Signed divide via magnitudes. The most-negative value's magnitude is
  // 2^(WIDTH-1), which still fits unsigned in WIDTH bits, so MIN / -1 comes
  // out as quotient 2^(WIDTH-1) (= MIN when read as signed) and remainder 0
  // without a special case.
  assign w_mag_a  = w_sign_a ? (-r_a) : r_a;
  assign w_mag_b  = w_sign_b ? (-r_b) : r_b;
  assign w_b_zero = (r_b == '0);
  // Keep the divider input non-zero so it never produces X; the result is
  // discarded on divide-by-zero anyway.
  assign w_div_b  = w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_mag_b;
  assign w_q_mag  = w_mag_a / w_div_b;
  assign w_r_mag  = w_mag_a % w_div_b;
  // Quotient truncates toward zero; remainder takes the dividend's sign.
  assign w_quot   = (w_sign_a ^ w_sign_b) ? (-w_q_mag) : w_q_mag;
  assign w_rem    = w_sign_a ? (-w_r_mag) : w_r_mag;

  assign w_accept_md = bus.start && (r_state == S_IDLE) &&
                       ((bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                        (bus.op == OP_DIV)  || (bus.op == OP_DIVU));
  assign w_last      = (r_state == S_BUSY) && (r_cnt == CW'(1));

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_a_nxt           = r_a;
    w_b_nxt           = r_b;
    w_is_div_nxt      = r_is_div;
    w_is_unsigned_nxt = r_is_unsigned;
    w_hi_nxt          = r_hi;
    w_lo_nxt          = r_lo;
    w_busy_nxt        = r_busy;
    w_done_nxt        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept_md) begin
          w_a_nxt           = bus.A;
          w_b_nxt           = bus.B;
          w_is_div_nxt      = bus.op[1];
          w_is_unsigned_nxt = bus.op[0];
          w_cnt_nxt         = bus.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          w_busy_nxt        = 1'b1;
          w_state_nxt       = S_BUSY;
        end else if (bus.start && (bus.op == OP_MTHI)) begin
          w_hi_nxt = bus.A;
        end else if (bus.start && (bus.op == OP_MTLO)) begin
          w_lo_nxt = bus.A;
        end
        // 110/111 fall through with no effect.
      end

      S_BUSY: begin
        // start is not looked at here: a second issue while busy is dropped.
        w_cnt_nxt = r_cnt - CW'(1);
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          if (!r_is_div) begin
            w_hi_nxt = w_prod[2*WIDTH-1:WIDTH];
            w_lo_nxt = w_prod[WIDTH-1:0];
          end else if (!w_b_zero) begin
            w_hi_nxt = w_rem;
            w_lo_nxt = w_quot;
          end
          // Divide by zero: full latency and done pulse, HI/LO untouched.
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset also discards latched operands so nothing in flight can
  // reach HI/LO after release.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_is_div      <= 1'b0;
      r_is_unsigned <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_a           <= w_a_nxt;
      r_b           <= w_b_nxt;
      r_is_div      <= w_is_div_nxt;
      r_is_unsigned <= w_is_unsigned_nxt;
      r_hi          <= w_hi_nxt;
      r_lo          <= w_lo_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rd_data = bus.rd_sel ? r_hi : r_lo;

endmodule
